// File: rtl/ecc_scalar_mult_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ecc_scalar_mult_ctrl_pkg
//   Shared definitions for the ECC scalar-multiplication sequencer:
//     - mode encodings BITS32..BITS256 (scalar width select)
//     - point-unit opcodes OP_LOAD / OP_DBL / OP_ADD
//     - controller FSM state encoding
//     - MAX_BITS / CNT_W defaults
//     - mode_width(): mode encoding -> active scalar width in bits
// ----------------------------------------------------------------------------
package ecc_scalar_mult_ctrl_pkg;

    localparam int MAX_BITS = 256;
    localparam int CNT_W    = 8;

    typedef enum logic [1:0] {
        BITS32  = 2'd0,
        BITS64  = 2'd1,
        BITS128 = 2'd2,
        BITS256 = 2'd3
    } mode_e;

    // LOAD: R <= base point, DBL: R <= 2R, ADD: R <= R + base
    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_DBL  = 2'd1,
        OP_ADD  = 2'd2
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic int mode_width(input mode_e m);
        int w;
        case (m)
            BITS32:  w = 32;
            BITS64:  w = 64;
            BITS128: w = 128;
            default: w = 256;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ecc_scalar_mult_ctrl_if.sv
// ----------------------------------------------------------------------------
// ecc_scalar_mult_ctrl_if
//   Command channel between the scalar-mult controller and the point
//   add/double unit. Signal names keep the controller's point of view.
//     o_cmd_valid  ctrl -> unit   command valid
//     o_cmd_op     ctrl -> unit   opcode (op_e)
//     o_cmd_swap   ctrl -> unit   ladder swap bit
//     i_cmd_ready  unit -> ctrl   unit accepts command
//     i_unit_done  unit -> ctrl   1-cycle pulse, accepted command finished
//   Modports: master (controller), slave (point unit).
// ----------------------------------------------------------------------------
interface ecc_scalar_mult_ctrl_if;
    import ecc_scalar_mult_ctrl_pkg::*;

    logic o_cmd_valid;
    op_e  o_cmd_op;
    logic o_cmd_swap;
    logic i_cmd_ready;
    logic i_unit_done;

    modport master (
        output o_cmd_valid, o_cmd_op, o_cmd_swap,
        input  i_cmd_ready, i_unit_done
    );

    modport slave (
        input  o_cmd_valid, o_cmd_op, o_cmd_swap,
        output i_cmd_ready, i_unit_done
    );

endinterface

// File: rtl/ecc_scalar_mult_ctrl_bit_cursor.sv
// ----------------------------------------------------------------------------
// ecc_bit_cursor
//   Holds the width-masked scalar and the MSB-first bit-index down-counter.
//   Ports:
//     clk, rst       clock, async active-low reset
//     i_load         capture i_scalar (masked to the mode width), idx=width-1
//     i_mode         mode encoding used for the mask / start index
//     i_scalar       raw scalar
//     i_dec          decrement idx (caller guarantees idx > 0)
//     o_idx          current bit index
//     o_bit          latched scalar bit at o_idx
//     o_idx_zero     o_idx == 0
//     o_scalar_zero  latched (masked) scalar is all zeros
// ----------------------------------------------------------------------------
module ecc_bit_cursor
    import ecc_scalar_mult_ctrl_pkg::*;
#(
    parameter int MAX_BITS = 256,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [1:0]          i_mode,
    input  logic [MAX_BITS-1:0] i_scalar,
    input  logic                i_dec,
    output logic [CNT_W-1:0]    o_idx,
    output logic                o_bit,
    output logic                o_idx_zero,
    output logic                o_scalar_zero
);

    logic [MAX_BITS-1:0] r_scalar;
    logic [CNT_W-1:0]    r_idx;
    logic [MAX_BITS-1:0] w_masked;
    int                  w_width;

    assign w_width = mode_width(mode_e'(i_mode));

    // Bits at or above the active width never reach the sequencer, so a
    // stray high bit in a narrow mode cannot change the command trace.
    always_comb begin
        w_masked = '0;
        for (int i = 0; i < MAX_BITS; i++) begin
            if (i < w_width) w_masked[i] = i_scalar[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scalar <= '0;
            r_idx    <= '0;
        end else if (i_load) begin
            r_scalar <= w_masked;
            r_idx    <= CNT_W'(w_width - 1);
        end else if (i_dec) begin
            r_idx    <= r_idx - 1'b1;
        end
    end

    assign o_idx         = r_idx;
    assign o_bit         = r_scalar[r_idx];
    assign o_idx_zero    = (r_idx == '0);
    assign o_scalar_zero = (r_scalar == '0);

endmodule

// File: rtl/ecc_scalar_mult_ctrl.sv
// ----------------------------------------------------------------------------
// ecc_scalar_mult_ctrl
//   Sequencing controller for the ECC point-arithmetic unit. Walks the
//   scalar MSB first within the active width and issues LOAD / DBL / ADD
//   to the point unit, one outstanding command at a time.
//
//   Build option ECC_LADDER_EN:
//     defined   - constant-time Montgomery ladder: LOAD, then ADD,DBL per
//                 bit from width-1 down to 0 with o_cmd_swap = bit[idx]
//                 (2*width+1 commands regardless of the scalar).
//     undefined - double-and-add with leading-zero scan, o_cmd_swap = 0.
//
//   Ports:
//     clk, rst     clock, asynchronous active-low reset
//     i_start      start request, sampled only in IDLE
//     i_mode       0=32, 1=64, 2=128, 3=256 bits, latched with i_start
//     i_scalar     scalar P, latched with i_start
//     o_busy       high in every state except IDLE
//     cmd_if       command channel (valid/op/swap, ready, unit done)
//     o_bit_idx    index of the scalar bit currently processed
//     o_done       1-cycle pulse, result register valid
//     o_inf        result is the point at infinity; held until next start
// ----------------------------------------------------------------------------
module ecc_scalar_mult_ctrl
    import ecc_scalar_mult_ctrl_pkg::*;
#(
    parameter int MAX_BITS = ecc_scalar_mult_ctrl_pkg::MAX_BITS,
    parameter int CNT_W    = ecc_scalar_mult_ctrl_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [1:0]           i_mode,
    input  logic [MAX_BITS-1:0]  i_scalar,
    output logic                 o_busy,
    ecc_scalar_mult_ctrl_if.master cmd_if,
    output logic [CNT_W-1:0]     o_bit_idx,
    output logic                 o_done,
    output logic                 o_inf
);

    state_e r_state, w_state_nxt;
    op_e    r_op,    w_op_nxt;
    logic   r_inf,   w_inf_nxt;

    logic             w_load;
    logic             w_dec;
    logic [CNT_W-1:0] w_idx;
    logic             w_bit;
    logic             w_idx_zero;
    logic             w_scalar_zero;

    ecc_bit_cursor #(
        .MAX_BITS (MAX_BITS),
        .CNT_W    (CNT_W)
    ) u_cursor (
        .clk           (clk),
        .rst           (rst),
        .i_load        (w_load),
        .i_mode        (i_mode),
        .i_scalar      (i_scalar),
        .i_dec         (w_dec),
        .o_idx         (w_idx),
        .o_bit         (w_bit),
        .o_idx_zero    (w_idx_zero),
        .o_scalar_zero (w_scalar_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_LOAD;
            r_inf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_inf   <= w_inf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_inf_nxt   = r_inf;
        w_load      = 1'b0;
        w_dec       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_load    = 1'b1;
                    w_inf_nxt = 1'b0;
                    w_op_nxt  = OP_LOAD;
`ifdef ECC_LADDER_EN
                    // Ladder never skips leading zeros: LOAD goes out at once.
                    w_state_nxt = ST_ISSUE;
`else
                    w_state_nxt = ST_SCAN;
`endif
                end
            end

            // Leading-zero skip, one bit per cycle. Running off bit 0 means
            // the masked scalar had no set bit at all.
            ST_SCAN: begin
                if (w_bit) begin
                    w_op_nxt    = OP_LOAD;
                    w_state_nxt = ST_ISSUE;
                end else if (!w_idx_zero) begin
                    w_dec = 1'b1;
                end else begin
                    w_inf_nxt   = w_scalar_zero;
                    w_state_nxt = ST_DONE;
                end
            end

            ST_ISSUE: begin
                if (cmd_if.i_cmd_ready) w_state_nxt = ST_WAIT;
            end

            ST_WAIT: begin
                if (cmd_if.i_unit_done) begin
                    w_state_nxt = ST_ISSUE;
`ifdef ECC_LADDER_EN
                    case (r_op)
                        OP_LOAD: w_op_nxt = OP_ADD;
                        OP_ADD:  w_op_nxt = OP_DBL;
                        default: begin
                            // DBL closes a bit: step down or finish.
                            if (!w_idx_zero) begin
                                w_dec    = 1'b1;
                                w_op_nxt = OP_ADD;
                            end else begin
                                w_inf_nxt   = w_scalar_zero;
                                w_state_nxt = ST_DONE;
                            end
                        end
                    endcase
`else
                    // After LOAD/ADD the current bit is consumed: move down
                    // and double. After DBL the ADD for this bit (if set)
                    // still has to go out before moving on.
                    if (r_op != OP_DBL && !w_idx_zero) begin
                        w_dec    = 1'b1;
                        w_op_nxt = OP_DBL;
                    end else if (r_op == OP_DBL && w_bit) begin
                        w_op_nxt = OP_ADD;
                    end else if (!w_idx_zero) begin
                        w_dec    = 1'b1;
                        w_op_nxt = OP_DBL;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
`endif
                end
            end

            ST_DONE: w_state_nxt = ST_IDLE;

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_busy             = (r_state != ST_IDLE);
    assign o_done             = (r_state == ST_DONE);
    assign o_inf              = r_inf;
    assign o_bit_idx          = w_idx;
    assign cmd_if.o_cmd_valid = (r_state == ST_ISSUE);
    assign cmd_if.o_cmd_op    = r_op;

`ifdef ECC_LADDER_EN
    // idx only moves in WAIT, so swap is stable for the whole ISSUE phase.
    assign cmd_if.o_cmd_swap  = (r_state == ST_ISSUE) && (r_op != OP_LOAD) && w_bit;
`else
    assign cmd_if.o_cmd_swap  = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
module tb_ecc_scalar_mult_ctrl;

    localparam int MB   = 256;
    localparam int CW   = 8;
    localparam int LOAD = 0;
    localparam int DBL  = 1;
    localparam int ADD  = 2;

    typedef struct { int op; int idx; int swap; } cmd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_start = 1'b0;
    logic [1:0]    i_mode = 2'd0;
    logic [MB-1:0] i_scalar = '0;
    logic          o_busy, o_done, o_inf;
    logic [CW-1:0] o_bit_idx;

    ecc_scalar_mult_ctrl_if ifc ();

    ecc_scalar_mult_ctrl #(.MAX_BITS(MB), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_mode    (i_mode),
        .i_scalar  (i_scalar),
        .o_busy    (o_busy),
        .cmd_if    (ifc),
        .o_bit_idx (o_bit_idx),
        .o_done    (o_done),
        .o_inf     (o_inf)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_chk = 0, n_err = 0;
    cmd_t exp_q[$];
    bit   exp_inf = 0;
    bit   active = 0;
    int   n_xfer = 0, n_stall = 0, n_done = 0;
    int   done_cyc = 0, start_cyc = 0;
    int   lat_g = 2, rmode_g = 0;
    bit   spur_en = 0;

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int enc(input int op, input int idx, input int swap);
        return swap * 100000 + op * 1000 + idx;
    endfunction

    // Reference: expected command list from the scalar-multiplication algorithm.
    function automatic void build_model(input int mode, input logic [MB-1:0] sc);
        int w;
        int msb;
        logic [MB-1:0] s;
        w   = 32 << mode;
        s   = '0;
        msb = -1;
        for (int i = 0; i < w; i++) s[i] = sc[i];
        exp_q.delete();
        exp_inf = (s == '0);
`ifdef ECC_LADDER_EN
        exp_q.push_back('{op:LOAD, idx:w-1, swap:0});
        for (int i = w - 1; i >= 0; i--) begin
            exp_q.push_back('{op:ADD, idx:i, swap:int'(s[i])});
            exp_q.push_back('{op:DBL, idx:i, swap:int'(s[i])});
        end
`else
        for (int i = 0; i < w; i++) if (s[i]) msb = i;
        if (msb >= 0) begin
            exp_q.push_back('{op:LOAD, idx:msb, swap:0});
            for (int i = msb - 1; i >= 0; i--) begin
                exp_q.push_back('{op:DBL, idx:i, swap:0});
                if (s[i]) exp_q.push_back('{op:ADD, idx:i, swap:0});
            end
        end
`endif
    endfunction

    // Point-unit model: ready policy, done pulse lat_g cycles after accept,
    // optional spurious done pulses while nothing is outstanding.
    initial begin : unit_model
        int  dcnt;
        int  stall_cnt;
        bit  pend;
        dcnt = 0; stall_cnt = 0; pend = 0;
        ifc.i_cmd_ready = 1'b0;
        ifc.i_unit_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            ifc.i_unit_done = 1'b0;
            if (!rst) begin
                dcnt = 0; pend = 0; stall_cnt = 0;
                ifc.i_cmd_ready = 1'b0;
            end else begin
                if (pend) dcnt = lat_g;
                else if (dcnt > 0) begin
                    dcnt--;
                    if (dcnt == 0) ifc.i_unit_done = 1'b1;
                end else if (spur_en && $urandom_range(7) == 0) ifc.i_unit_done = 1'b1;
                case (rmode_g)
                    0: ifc.i_cmd_ready = 1'b1;
                    1: ifc.i_cmd_ready = ($urandom_range(3) != 0);
                    default: begin
                        ifc.i_cmd_ready = 1'b1;
                        if (ifc.o_cmd_valid && int'(ifc.o_cmd_op) == DBL && stall_cnt < 3) begin
                            ifc.i_cmd_ready = 1'b0;
                            stall_cnt++;
                        end
                    end
                endcase
                pend = ifc.o_cmd_valid && ifc.i_cmd_ready;
            end
        end
    end

    // Compare process: every transfer, every stalled cycle, every done pulse.
    initial begin : monitor
        bit   stalled;
        int   s_op, s_idx, s_swap;
        cmd_t c;
        stalled = 0; s_op = 0; s_idx = 0; s_swap = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (ifc.o_cmd_valid) chk(o_busy, "busy_with_valid", o_busy, 1);
                if (stalled)
                    chk(ifc.o_cmd_valid && int'(ifc.o_cmd_op) == s_op && int'(o_bit_idx) == s_idx
                        && int'(ifc.o_cmd_swap) == s_swap, "stall_hold",
                        enc(int'(ifc.o_cmd_op), int'(o_bit_idx), int'(ifc.o_cmd_swap)),
                        enc(s_op, s_idx, s_swap));
                if (ifc.o_cmd_valid && !ifc.i_cmd_ready && int'(ifc.o_cmd_op) == DBL) n_stall++;
                if (ifc.o_cmd_valid && ifc.i_cmd_ready) begin
                    n_xfer++;
                    if (exp_q.size() == 0)
                        chk(1'b0, "extra_cmd", enc(int'(ifc.o_cmd_op), int'(o_bit_idx), int'(ifc.o_cmd_swap)), -1);
                    else begin
                        c = exp_q.pop_front();
                        chk(int'(ifc.o_cmd_op) == c.op && int'(o_bit_idx) == c.idx && int'(ifc.o_cmd_swap) == c.swap,
                            "cmd", enc(int'(ifc.o_cmd_op), int'(o_bit_idx), int'(ifc.o_cmd_swap)),
                            enc(c.op, c.idx, c.swap));
                    end
                end
                stalled = ifc.o_cmd_valid && !ifc.i_cmd_ready;
                s_op    = int'(ifc.o_cmd_op);
                s_idx   = int'(o_bit_idx);
                s_swap  = int'(ifc.o_cmd_swap);
                if (o_done) begin
                    chk(active, "done_expected", o_done, active);
                    chk(exp_q.size() == 0, "cmd_count_left", exp_q.size(), 0);
                    chk(o_inf == exp_inf, "inf_at_done", o_inf, exp_inf);
                    active   = 0;
                    done_cyc = cyc;
                    n_done++;
                end
            end else begin
                stalled = 0;
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while (o_busy && k < 2000) begin @(negedge clk); k++; end
        chk(!o_busy, "idle_timeout", k, 2000);
    endtask

    task automatic start_op(input int mode, input logic [MB-1:0] sc);
        build_model(mode, sc);
        active = 1;
        @(posedge clk); #1;
        i_start   = 1'b1;
        i_mode    = mode[1:0];
        i_scalar  = sc;
        start_cyc = cyc;
        @(posedge clk); #1;
        i_start   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (active && k < budget) begin @(negedge clk); k++; end
        chk(!active, "done_timeout", k, budget);
        active = 0;
    endtask

    task automatic run_op(input int mode, input logic [MB-1:0] sc, input int lat, input int rmode);
        lat_g = lat; rmode_g = rmode;
        wait_idle();
        start_op(mode, sc);
        wait_done(9000);
        @(negedge clk);
        chk(!o_busy, "idle_after_done", o_busy, 0);
        chk(o_inf == exp_inf, "inf_held", o_inf, exp_inf);
    endtask

    task automatic chk_reset_outputs();
        chk(!o_busy, "rst_busy", o_busy, 0);
        chk(!ifc.o_cmd_valid && int'(ifc.o_cmd_op) == 0 && !ifc.o_cmd_swap, "rst_cmd",
            enc(int'(ifc.o_cmd_op), int'(ifc.o_cmd_valid), int'(ifc.o_cmd_swap)), 0);
        chk(o_bit_idx == '0, "rst_idx", o_bit_idx, 0);
        chk(!o_done && !o_inf, "rst_done_inf", {o_done, o_inf}, 0);
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int x0;
        int k;
        logic [MB-1:0] sc;
        int e5 [4];
        e5 = '{enc(LOAD, 2, 0), enc(DBL, 1, 0), enc(DBL, 0, 0), enc(ADD, 0, 0)};

        // Pin the model against hand-derived traces.
`ifdef ECC_LADDER_EN
        build_model(0, 256'h3);
        chk(exp_q.size() == 65, "model_ladder_len", exp_q.size(), 65);
        chk(enc(exp_q[0].op, exp_q[0].idx, exp_q[0].swap) == enc(LOAD, 31, 0), "model_ladder_0",
            enc(exp_q[0].op, exp_q[0].idx, exp_q[0].swap), enc(LOAD, 31, 0));
        chk(enc(exp_q[59].op, exp_q[59].idx, exp_q[59].swap) == enc(ADD, 2, 0), "model_ladder_59",
            enc(exp_q[59].op, exp_q[59].idx, exp_q[59].swap), enc(ADD, 2, 0));
        chk(enc(exp_q[61].op, exp_q[61].idx, exp_q[61].swap) == enc(ADD, 1, 1), "model_ladder_61",
            enc(exp_q[61].op, exp_q[61].idx, exp_q[61].swap), enc(ADD, 1, 1));
        chk(enc(exp_q[64].op, exp_q[64].idx, exp_q[64].swap) == enc(DBL, 0, 1), "model_ladder_64",
            enc(exp_q[64].op, exp_q[64].idx, exp_q[64].swap), enc(DBL, 0, 1));
`else
        build_model(0, 256'h5);
        chk(exp_q.size() == 4, "model_len5", exp_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk(enc(exp_q[i].op, exp_q[i].idx, exp_q[i].swap) == e5[i], "model_trace5",
                enc(exp_q[i].op, exp_q[i].idx, exp_q[i].swap), e5[i]);
        build_model(0, 256'h1_0000_0005);
        chk(exp_q.size() == 4, "model_len_hi", exp_q.size(), 4);
        build_model(0, 256'h0);
        chk(exp_q.size() == 0 && exp_inf, "model_zero", exp_q.size(), 0);
`endif
        exp_q.delete();

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b1;

        // Basic trace, zero scalar, out-of-width bit, stalled DBL
        run_op(0, 256'h5, 2, 0);
        x0 = n_xfer;
        run_op(0, 256'h0, 2, 0);
`ifndef ECC_LADDER_EN
        chk(done_cyc - start_cyc == 33, "zero_done_latency", done_cyc - start_cyc, 33);
        chk(n_xfer == x0, "zero_no_cmds", n_xfer - x0, 0);
`endif
        run_op(0, 256'h1_0000_0005, 2, 0);
        n_stall = 0;
        run_op(0, 256'h5, 2, 2);
        chk(n_stall == 3, "dbl_stall_cycles", n_stall, 3);
        run_op(0, 256'h3, 1, 1);

        // Start ignored while busy, then reset mid-operation
        lat_g = 2; rmode_g = 0;
        wait_idle();
        x0 = n_xfer;
        start_op(3, '1);
        k = 0;
        while (n_xfer < x0 + 3 && k < 500) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        i_start = 1'b1; i_mode = 2'd0; i_scalar = 256'h1;
        @(posedge clk); #1;
        i_start = 1'b0;
        k = 0;
        while (n_xfer < x0 + 10 && k < 500) begin @(negedge clk); k++; end
        chk(n_xfer >= x0 + 10, "ten_cmds_reached", n_xfer - x0, 10);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        active = 0;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b1;
        x0 = n_xfer;
        run_op(0, 256'h1, 2, 0);
`ifndef ECC_LADDER_EN
        chk(n_xfer - x0 == 1, "post_reset_single_load", n_xfer - x0, 1);
`endif

        // Randomized runs with spurious done pulses
        spur_en = 1;
        for (int r = 0; r < 12; r++) begin
            sc = '0;
            case ($urandom_range(3))
                0: sc = '0;
                1: sc[$urandom_range(MB - 1)] = 1'b1;
                default: for (int j = 0; j < MB / 32; j++) sc[j*32 +: 32] = $urandom;
            endcase
            run_op($urandom_range(3), sc, $urandom_range(1, 3), $urandom_range(1));
        end
        spur_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
